// File: rtl/memcard_responder.sv
// Card-side SD command-line agent: receives 48-bit host commands, exposes them through a CSR bank and
// transmits software-supplied 48-bit responses. Define MEMCARD_RESPONDER_CRC_EN to add CRC7 check/insertion.
module memcard_responder #(
    parameter logic [3:0] csr_addr = 4'h0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    input  logic        mc_clk,
    input  logic        mc_cmd_i,
    output logic        mc_cmd_o,
    output logic        mc_cmd_oe
);

    typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_WAIT, TX_SHIFT} tx_state_t;

`ifdef MEMCARD_RESPONDER_CRC_EN
    function automatic logic [6:0] crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction
`endif

    logic        clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_s3_q, clk_s3_d;
    logic        cmd_s1_q, cmd_s1_d, cmd_s2_q, cmd_s2_d;
    rx_state_t   rx_state_q, rx_state_d;
    logic [5:0]  rx_cnt_q, rx_cnt_d;
    logic [47:0] rx_shift_q, rx_shift_d;
    logic        rx_done_q, rx_done_d;
    logic        cmd_valid_q, cmd_valid_d, crc_err_q, crc_err_d, overrun_q, overrun_d;
    logic [15:0] cmd_hi_q, cmd_hi_d;
    logic [31:0] cmd_lo_q, cmd_lo_d;
    logic [15:0] resp_hi_q, resp_hi_d;
    logic [31:0] resp_lo_q, resp_lo_d;
    logic [5:0]  ncr_q, ncr_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [5:0]  tx_cnt_q, tx_cnt_d;
    logic [47:0] tx_shift_q, tx_shift_d;
    logic        cmd_o_q, cmd_o_d, cmd_oe_q, cmd_oe_d;
    logic [31:0] csr_do_q, csr_do_d;

    logic        rise, fall, sel, wr, tx_busy, start, frame_bad;
    logic [2:0]  reg_sel;
    logic [5:0]  ncr_eff;
    logic [47:0] tx_frame;
    logic [31:0] rd_data;

    assign rise    = clk_s2_q & ~clk_s3_q;
    assign fall    = ~clk_s2_q & clk_s3_q;
    assign sel     = (csr_a[13:10] == csr_addr);
    assign wr      = csr_we & sel;
    assign reg_sel = csr_a[2:0];
    assign tx_busy = (tx_state_q != TX_IDLE);
    assign ncr_eff = (ncr_q < 6'd2) ? 6'd2 : ncr_q;
    assign start   = wr && (reg_sel == 3'd0) && csr_di[4] && !tx_busy;

`ifdef MEMCARD_RESPONDER_CRC_EN
    assign tx_frame  = {resp_hi_q, resp_lo_q[31:8], crc7({resp_hi_q, resp_lo_q[31:8]}), 1'b1};
    assign frame_bad = rx_shift_q[47] | ~rx_shift_q[46] | ~rx_shift_q[0]
                     | (crc7(rx_shift_q[47:8]) != rx_shift_q[7:1]);
`else
    assign tx_frame  = {resp_hi_q, resp_lo_q};
    assign frame_bad = rx_shift_q[47] | ~rx_shift_q[46] | ~rx_shift_q[0];
`endif

    always_comb begin
        clk_s1_d    = mc_clk;
        clk_s2_d    = clk_s1_q;
        clk_s3_d    = clk_s2_q;
        cmd_s1_d    = mc_cmd_i;
        cmd_s2_d    = cmd_s1_q;
        rx_state_d  = rx_state_q;
        rx_cnt_d    = rx_cnt_q;
        rx_shift_d  = rx_shift_q;
        rx_done_d   = 1'b0;
        cmd_valid_d = cmd_valid_q;
        crc_err_d   = crc_err_q;
        overrun_d   = overrun_q;
        cmd_hi_d    = cmd_hi_q;
        cmd_lo_d    = cmd_lo_q;
        resp_hi_d   = resp_hi_q;
        resp_lo_d   = resp_lo_q;
        ncr_d       = ncr_q;
        tx_state_d  = tx_state_q;
        tx_cnt_d    = tx_cnt_q;
        tx_shift_d  = tx_shift_q;
        cmd_o_d     = cmd_o_q;
        cmd_oe_d    = cmd_oe_q;
        rd_data     = '0;

        unique case (rx_state_q)
            RX_IDLE: begin
                if (rise && !cmd_s2_q && !tx_busy) begin
                    rx_shift_d = {rx_shift_q[46:0], 1'b0};
                    rx_cnt_d   = 6'd1;
                    rx_state_d = RX_SHIFT;
                end
            end
            RX_SHIFT: begin
                if (rise) begin
                    rx_shift_d = {rx_shift_q[46:0], cmd_s2_q};
                    rx_cnt_d   = rx_cnt_q + 6'd1;
                    if (rx_cnt_q == 6'd47) begin
                        rx_state_d = RX_IDLE;
                        rx_done_d  = 1'b1;
                    end
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase

        // W1C first so a simultaneous hardware set below takes priority.
        if (wr && reg_sel == 3'd0) begin
            if (csr_di[0]) cmd_valid_d = 1'b0;
            if (csr_di[1]) crc_err_d   = 1'b0;
            if (csr_di[3]) overrun_d   = 1'b0;
        end
        if (rx_done_q) begin
            if (cmd_valid_q) begin
                overrun_d = 1'b1;
            end else begin
                cmd_hi_d    = rx_shift_q[47:32];
                cmd_lo_d    = rx_shift_q[31:0];
                cmd_valid_d = 1'b1;
                if (frame_bad) crc_err_d = 1'b1;
            end
        end
        if (wr && reg_sel == 3'd3) resp_hi_d = csr_di[15:0];
        if (wr && reg_sel == 3'd4) resp_lo_d = csr_di;
        if (wr && reg_sel == 3'd5) ncr_d     = csr_di[5:0];

        unique case (tx_state_q)
            TX_IDLE: begin
                if (start) begin
                    tx_shift_d = tx_frame;
                    tx_cnt_d   = ncr_eff;
                    tx_state_d = TX_WAIT;
                end
            end
            TX_WAIT: begin
                if (fall) begin
                    if (tx_cnt_q == 6'd0) begin
                        cmd_o_d    = tx_shift_q[47];
                        cmd_oe_d   = 1'b1;
                        tx_shift_d = {tx_shift_q[46:0], 1'b0};
                        tx_cnt_d   = 6'd47;
                        tx_state_d = TX_SHIFT;
                    end else begin
                        tx_cnt_d = tx_cnt_q - 6'd1;
                    end
                end
            end
            TX_SHIFT: begin
                // tx_cnt holds the number of bits still to drive after the current one.
                if (fall) begin
                    if (tx_cnt_q == 6'd0) begin
                        cmd_o_d    = 1'b1;
                        cmd_oe_d   = 1'b0;
                        tx_state_d = TX_IDLE;
                    end else begin
                        cmd_o_d    = tx_shift_q[47];
                        tx_shift_d = {tx_shift_q[46:0], 1'b0};
                        tx_cnt_d   = tx_cnt_q - 6'd1;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase

        unique case (reg_sel)
            3'd0:    rd_data = {28'd0, overrun_q, tx_busy, crc_err_q, cmd_valid_q};
            3'd1:    rd_data = {16'd0, cmd_hi_q};
            3'd2:    rd_data = cmd_lo_q;
            3'd3:    rd_data = {16'd0, resp_hi_q};
            3'd4:    rd_data = resp_lo_q;
            3'd5:    rd_data = {26'd0, ncr_q};
            default: rd_data = '0;
        endcase
        csr_do_d = sel ? rd_data : 32'd0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            clk_s1_q    <= 1'b0;
            clk_s2_q    <= 1'b0;
            clk_s3_q    <= 1'b0;
            cmd_s1_q    <= 1'b1;
            cmd_s2_q    <= 1'b1;
            rx_state_q  <= RX_IDLE;
            rx_cnt_q    <= '0;
            rx_shift_q  <= '0;
            rx_done_q   <= 1'b0;
            cmd_valid_q <= 1'b0;
            crc_err_q   <= 1'b0;
            overrun_q   <= 1'b0;
            cmd_hi_q    <= '0;
            cmd_lo_q    <= '0;
            resp_hi_q   <= '0;
            resp_lo_q   <= '0;
            ncr_q       <= 6'd2;
            tx_state_q  <= TX_IDLE;
            tx_cnt_q    <= '0;
            tx_shift_q  <= '0;
            cmd_o_q     <= 1'b1;
            cmd_oe_q    <= 1'b0;
            csr_do_q    <= '0;
        end else begin
            clk_s1_q    <= clk_s1_d;
            clk_s2_q    <= clk_s2_d;
            clk_s3_q    <= clk_s3_d;
            cmd_s1_q    <= cmd_s1_d;
            cmd_s2_q    <= cmd_s2_d;
            rx_state_q  <= rx_state_d;
            rx_cnt_q    <= rx_cnt_d;
            rx_shift_q  <= rx_shift_d;
            rx_done_q   <= rx_done_d;
            cmd_valid_q <= cmd_valid_d;
            crc_err_q   <= crc_err_d;
            overrun_q   <= overrun_d;
            cmd_hi_q    <= cmd_hi_d;
            cmd_lo_q    <= cmd_lo_d;
            resp_hi_q   <= resp_hi_d;
            resp_lo_q   <= resp_lo_d;
            ncr_q       <= ncr_d;
            tx_state_q  <= tx_state_d;
            tx_cnt_q    <= tx_cnt_d;
            tx_shift_q  <= tx_shift_d;
            cmd_o_q     <= cmd_o_d;
            cmd_oe_q    <= cmd_oe_d;
            csr_do_q    <= csr_do_d;
        end
    end

    assign csr_do    = csr_do_q;
    assign mc_cmd_o  = cmd_o_q;
    assign mc_cmd_oe = cmd_oe_q;

endmodule

// File: tb/tb_memcard_responder.sv
// Directed bench for memcard_responder: CSR vector table plus host-side command/response sequences.
module tb_memcard_responder;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [13:0] csr_a   = '0;
    logic        csr_we  = 1'b0;
    logic [31:0] csr_di  = '0;
    logic [31:0] csr_do;
    logic        mc_clk   = 1'b0;
    logic        mc_cmd_i = 1'b1;
    logic        mc_cmd_o, mc_cmd_oe;

    int tests_run = 0;
    int tests_failed = 0;

    logic oe_hist [0:63];
    logic line_hist [0:63];

    memcard_responder #(.csr_addr(4'h0)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_di   (csr_di),
        .csr_do   (csr_do),
        .mc_clk   (mc_clk),
        .mc_cmd_i (mc_cmd_i),
        .mc_cmd_o (mc_cmd_o),
        .mc_cmd_oe(mc_cmd_oe)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [13:0] addr;
        logic        we;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

`ifdef MEMCARD_RESPONDER_CRC_EN
    function automatic logic [6:0] ref_crc7(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = '0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0};
            if (fb) crc = crc ^ 7'h09;
        end
        return crc;
    endfunction
`endif

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("[TB] pass %s = %h", name, got);
        end
    endtask

    task automatic csr_write(input logic [13:0] addr, input logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = addr;
        csr_di = data;
        csr_we = 1'b1;
        @(negedge sys_clk);
        csr_we = 1'b0;
    endtask

    task automatic csr_read(input logic [13:0] addr, output logic [31:0] data);
        @(negedge sys_clk);
        csr_a  = addr;
        csr_we = 1'b0;
        @(negedge sys_clk);
        data = csr_do;
    endtask

    task automatic read_check(input string name, input logic [13:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        csr_read(addr, d);
        check(name, {32'd0, d}, {32'd0, exp});
    endtask

    // Host sends a frame MSB-first; data changes while mc_clk is low, card samples on rise.
    task automatic send_frame(input logic [47:0] frame);
        for (int i = 47; i >= 0; i--) begin
            mc_clk   = 1'b0;
            mc_cmd_i = frame[i];
            #40;
            mc_clk = 1'b1;
            #40;
        end
        mc_clk   = 1'b0;
        mc_cmd_i = 1'b1;
        repeat (12) @(posedge sys_clk);
    endtask

    // Each cycle is rise then fall; entry k records the line just before the next rise, i.e. after fall k+1.
    task automatic host_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            mc_clk = 1'b1;
            #40;
            mc_clk = 1'b0;
            #40;
            oe_hist[k]   = mc_cmd_oe;
            line_hist[k] = mc_cmd_oe ? mc_cmd_o : 1'b1;
        end
    endtask

    task automatic check_tx(input string name, input int ncr_eff, input logic [47:0] exp_frame);
        logic [47:0] got;
        got = '0;
        host_cycles(56);
        check({name, "_oe_before"}, {63'd0, oe_hist[ncr_eff-1]}, 64'd0);
        check({name, "_oe_first"}, {63'd0, oe_hist[ncr_eff]}, 64'd1);
        for (int k = 0; k < 48; k++) got = {got[46:0], line_hist[ncr_eff+k]};
        check({name, "_frame"}, {16'd0, got}, {16'd0, exp_frame});
        check({name, "_released"}, {63'd0, oe_hist[ncr_eff+48]}, 64'd0);
    endtask

    initial begin
        #2ms;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs [17];
        logic [47:0] exp_resp;
        logic [31:0] exp_stat;

        vecs[0]  = '{14'h0000, 1'b0, 32'h0, 32'h0};
        vecs[1]  = '{14'h0001, 1'b0, 32'h0, 32'h0};
        vecs[2]  = '{14'h0002, 1'b0, 32'h0, 32'h0};
        vecs[3]  = '{14'h0003, 1'b0, 32'h0, 32'h0};
        vecs[4]  = '{14'h0004, 1'b0, 32'h0, 32'h0};
        vecs[5]  = '{14'h0005, 1'b0, 32'h0, 32'h2};
        vecs[6]  = '{14'h0003, 1'b1, 32'hdead7f01, 32'h0};
        vecs[7]  = '{14'h0003, 1'b0, 32'h0, 32'h00007f01};
        vecs[8]  = '{14'h0004, 1'b1, 32'h02030405, 32'h0};
        vecs[9]  = '{14'h0004, 1'b0, 32'h0, 32'h02030405};
        vecs[10] = '{14'h0005, 1'b1, 32'hffffffc5, 32'h0};
        vecs[11] = '{14'h0005, 1'b0, 32'h0, 32'h5};
        vecs[12] = '{14'h0403, 1'b0, 32'h0, 32'h0};
        vecs[13] = '{14'h0405, 1'b1, 32'h9, 32'h0};
        vecs[14] = '{14'h0005, 1'b0, 32'h0, 32'h5};
        vecs[15] = '{14'h0005, 1'b1, 32'h2, 32'h0};
        vecs[16] = '{14'h0005, 1'b0, 32'h0, 32'h2};

        exp_resp = 48'h7f0102030405;
`ifdef MEMCARD_RESPONDER_CRC_EN
        exp_resp[7:1] = ref_crc7(exp_resp[47:8]);
        exp_resp[0]   = 1'b1;
`endif

        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_csr_do", {32'd0, csr_do}, 64'd0);
        check("rst_cmd_o", {63'd0, mc_cmd_o}, 64'd1);
        check("rst_cmd_oe", {63'd0, mc_cmd_oe}, 64'd0);

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].we) csr_write(vecs[i].addr, vecs[i].data);
            else read_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
        end

        // CMD17 reception
        send_frame(48'h510000000055);
        read_check("cmd17_stat", 14'h0000, 32'h1);
        read_check("cmd17_hi", 14'h0001, 32'h5100);
        read_check("cmd17_lo", 14'h0002, 32'h55);
        csr_write(14'h0000, 32'h3);
        read_check("cmd17_clr", 14'h0000, 32'h0);

        // CRC field corrupted: only flagged when CRC checking is built in
        send_frame(48'h510000000057);
`ifdef MEMCARD_RESPONDER_CRC_EN
        exp_stat = 32'h3;
`else
        exp_stat = 32'h1;
`endif
        read_check("crcfld_stat", 14'h0000, exp_stat);
        csr_write(14'h0000, 32'hb);

        // Framing error: transmission bit (bit46) is 0
        send_frame(48'h110000000055);
        read_check("framing_stat", 14'h0000, 32'h3);
        csr_write(14'h0000, 32'hb);

        // Overrun: second frame discarded
        send_frame(48'h510000000055);
        send_frame(48'h4c0000000001);
        read_check("ovr_stat", 14'h0000, 32'h9);
        read_check("ovr_hi", 14'h0001, 32'h5100);
        read_check("ovr_lo", 14'h0002, 32'h55);
        csr_write(14'h0000, 32'h9);
        read_check("ovr_clr", 14'h0000, 32'h0);

        // Response with NCR=2
        csr_write(14'h0005, 32'h2);
        csr_write(14'h0000, 32'h10);
        read_check("tx_busy", 14'h0000, 32'h4);
        check_tx("resp_ncr2", 2, exp_resp);
        read_check("tx_done_stat", 14'h0000, 32'h0);

        // NCR=5, second start ignored, RESP_LO rewritten mid-flight
        csr_write(14'h0005, 32'h5);
        csr_write(14'h0000, 32'h10);
        csr_write(14'h0000, 32'h10);
        csr_write(14'h0004, 32'h0);
        check_tx("resp_ncr5", 5, exp_resp);
        read_check("ncr5_stat", 14'h0000, 32'h0);
        csr_write(14'h0004, 32'h02030405);

        // NCR=0 behaves as 2
        csr_write(14'h0005, 32'h0);
        csr_write(14'h0000, 32'h10);
        check_tx("resp_ncr0", 2, exp_resp);

        // Reset during TX_SHIFT
        csr_write(14'h0005, 32'h3);
        csr_write(14'h0000, 32'h10);
        host_cycles(10);
        check("mid_tx_oe", {63'd0, mc_cmd_oe}, 64'd1);
        @(negedge sys_clk);
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        check("rst_tx_oe", {63'd0, mc_cmd_oe}, 64'd0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        read_check("rst_tx_stat", 14'h0000, 32'h0);
        read_check("rst_tx_ncr", 14'h0005, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/memcard_responder.md
# memcard_responder

Card-side agent for the SD command line of the `memcard` host controller. It receives 48-bit command frames from the host on `mc_cmd`, clocked by `mc_clk`, and checks their CRC7. Software reads each command through a CSR bank and answers with a 48-bit response frame. It is used as a synthesizable card emulator for loopback testing of the host core in hardware and in simulation.

## Interface
- `csr_addr`, default 4'h0: CSR bank select, compared to `csr_a[13:10]`.
- `sys_clk` in 1: system clock; all logic runs on it.
- `sys_rst` in 1: synchronous, active-high reset.
- `csr_a` in 14: CSR word address; `csr_a[2:0]` selects the register.
- `csr_we` in 1: CSR write strobe.
- `csr_di` in 32: CSR write data.
- `csr_do` out 32: CSR read data; registered; 0 when the bank is not selected.
- `mc_clk` in 1: card clock from the host; asynchronous to `sys_clk`.
- `mc_cmd_i` in 1: command line input (pulled up externally).
- `mc_cmd_o` out 1: command line drive value.
- `mc_cmd_oe` out 1: command line output enable.

## Operation
- `mc_clk` and `mc_cmd_i` each pass through two synchronizer flops.
- A rise event is synchronized `mc_clk` going 0→1; a fall event is 1→0.
- Register map, by `csr_a[2:0]`:
  - 0 STAT: bit0 `cmd_valid` (W1C), bit1 `crc_err` (W1C), bit2 `tx_busy` (RO), bit3 `overrun` (W1C). Writing bit4=1 starts a response; it is ignored while `tx_busy` is set.
  - 1 CMD_HI: received bits [47:32].
  - 2 CMD_LO: received bits [31:0].
  - 3 RESP_HI: RW [15:0]; transmitted bits [47:32].
  - 4 RESP_LO: RW; transmitted bits [31:0].
  - 5 NCR: RW [5:0]; reset 2; minimum effective value 2 (values 0 and 1 behave as 2).
- Receive FSM:
  - RX_IDLE: on a rise event with line=0 and `tx_busy`=0, shift in the 0 bit, set the bit counter to 1 and go to RX_SHIFT.
  - RX_SHIFT: shift in one bit MSB-first on each rise event. When the counter reaches 48, return to RX_IDLE and evaluate the frame.
  - If `cmd_valid` is already 1, the frame is discarded and `overrun` is set.
  - Otherwise CMD_HI/CMD_LO are loaded and `cmd_valid` is set.
  - `crc_err` is set if bit47≠0, bit46≠1, bit0≠1, or (macro enabled) the CRC check fails.
- Transmit FSM:
  - TX_IDLE → TX_WAIT on a start write; `tx_busy`=1.
  - TX_WAIT: count NCR fall events. The line is not driven.
  - TX_SHIFT: on each fall event drive the next frame bit MSB-first with `mc_cmd_oe`=1. After bit 0 has been held for one full `mc_clk` period (the next fall event), release the line and return to TX_IDLE.
- The response frame is {RESP_HI[15:0], RESP_LO}, latched when the response starts. CSR writes to RESP_HI/RESP_LO during TX do not affect the frame in flight.

## Timing
- Reset values:
  - `csr_do`=0, `mc_cmd_o`=1, `mc_cmd_oe`=0.
  - All status bits 0, CMD_* 0, RESP_* 0, NCR=2.
  - Both FSMs idle.
- CSR reads have 1 cycle latency; `csr_do` updates on the `sys_clk` edge after `csr_a` is presented.
- CSR writes take effect on the same edge. If W1C and a hardware set happen in the same cycle, the hardware set wins.
- Received bits are sampled 3 `sys_clk` cycles after the physical `mc_clk` rise.
- `cmd_valid` rises 1 cycle after the 48th rise event.
- The first TX bit is driven on fall event NCR+1 after the start write, so the host sees ≥NCR clocks of high-Z (pulled-up 1).
- `mc_clk` high and low phases must each be ≥3 `sys_clk` periods. Faster clocks are unsupported and give undefined behaviour.
- Synchronous reset mid-frame aborts RX and TX immediately and releases the line on the next edge.

## Configuration
- `MEMCARD_RESPONDER_CRC_EN` defined:
  - RX computes CRC7 (poly x^7+x^3+1, init 0) over bits [47:8] and sets `crc_err` if it differs from bits [7:1].
  - TX replaces response bits [7:1] with the CRC7 computed over bits [47:8] and forces bit0=1.
- Not defined:
  - No CRC logic is instantiated.
  - The RX CRC field is not checked; only the framing bits can set `crc_err`.
  - TX sends RESP_LO[7:0] verbatim.

## Test plan
- CMD17 reception: host sends 0x510000000055 → CMD_HI=0x5100, CMD_LO=0x00000055, `cmd_valid`=1, `crc_err`=0.
- CRC failure (macro on): host sends 0x510000000057 → `cmd_valid`=1, `crc_err`=1.
- Overrun: two frames without clearing STAT → CMD_* hold the first frame and `overrun`=1. Writing STAT=0x9 clears both bits.
- Response: RESP_HI=0x7f01, RESP_LO=0x02030405, NCR=2, start → host receives 48 bits 0x7f0102030405 (macro off). Line is released afterwards and `tx_busy` returns to 0.
- Response latency with NCR=5: `mc_cmd_oe` asserts on the 6th fall event after the start write. A second start write while busy is ignored.
- Reset during TX_SHIFT: `sys_rst` asserted for 1 cycle → `mc_cmd_oe`=0 on the next edge, STAT=0, NCR=2.
